// File: rtl/pipe_reg_pkg.sv
//------------------------------------------------------------------------------
// Module   : pipe_reg_pkg
// Purpose  : Shared constants, state type and helpers for the pipe_reg_skid
//            pipeline stage register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_reg_pkg;

  // State encoding for the stage control FSM
  localparam logic [1:0] PR_EMPTY = 2'd0;
  localparam logic [1:0] PR_FULL  = 2'd1;
  localparam logic [1:0] PR_SKID  = 2'd2;

  // Width of the occupancy count (0, 1 or 2 entries)
  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = PR_EMPTY,
    ST_FULL  = PR_FULL,
    ST_SKID  = PR_SKID
  } pr_state_e;

  // Number of held entries for a given state
  function automatic logic [OCC_W-1:0] occ_of_state(input pr_state_e st);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (st)
      ST_FULL: occ = 2'd1;
      ST_SKID: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_reg_skid_if.sv
//------------------------------------------------------------------------------
// Module   : pipe_reg_skid_if
// Purpose  : Valid/ready handshake bundle around a pipe_reg_skid stage.
//            The stage uses the slave modport; the driving environment
//            (upstream producer + downstream consumer) uses master.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

import pipe_reg_pkg::*;

interface pipe_reg_skid_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
endinterface

`default_nettype wire

// File: rtl/pipe_reg_entry.sv
//------------------------------------------------------------------------------
// Module   : pipe_reg_entry
// Purpose  : WIDTH-bit data entry with asynchronous active-low reset to
//            RESET_VALUE, load enable and synchronous clear to RESET_VALUE.
//            Clear wins over load.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_reg_entry #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Data storage: reset/clear to RESET_VALUE, otherwise load or hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VALUE;
    end else if (clear) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_reg_skid.sv
//------------------------------------------------------------------------------
// Module   : pipe_reg_skid
// Purpose  : Two-entry valid/ready pipeline stage register with skid buffer.
//            in_ready and out_valid are decoded from the state register only,
//            so there is no combinational path from out_ready to in_ready.
//            Optional flush port enabled by defining PIPE_REG_FLUSH_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

import pipe_reg_pkg::*;

module pipe_reg_skid #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PIPE_REG_FLUSH_EN
  input  logic             flush,
`endif
  pipe_reg_skid_if.slave   bus
);

  pr_state_e        state_q;
  pr_state_e        state_d;
  logic             in_xfer;
  logic             out_xfer;
  logic             main_load;
  logic             skid_load;
  logic             main_from_skid;
  logic             flush_w;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

`ifdef PIPE_REG_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Handshake outputs come straight from the state register
  assign bus.in_ready  = (state_q != ST_SKID);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.occupancy = occ_of_state(state_q);
  assign bus.out_data  = main_q;

  assign in_xfer  = bus.in_valid  & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  // Refilling main from skid keeps order when the consumer drains SKID
  assign main_d = main_from_skid ? skid_q : bus.in_data;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and entry load decode; flush overrides every transfer
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_load = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (in_xfer) begin
          skid_load = 1'b1;
          state_d   = ST_SKID;
        end else if (out_xfer) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_xfer) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush_w) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  pipe_reg_entry #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (flush_w),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_reg_entry #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (flush_w),
    .d     (bus.in_data),
    .q     (skid_q)
  );

endmodule

`default_nettype wire
